buf_alloc_arbiter: RTL and testbench

// - Shares the buf_manager Wishbone slave (free buffer-ID pool) between NCLIENTS requesters.
// - Clients post alloc/free request pulses. The block serialises them round-robin into single

---
 rtl/buf_alloc_arbiter_pkg.sv | 20 ++
 rtl/buf_alloc_arbiter_rr_arbiter.sv | 31 +++
 rtl/buf_alloc_arbiter.sv | 148 ++++++++++++++
 tb/tb_buf_alloc_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/buf_alloc_arbiter_pkg.sv
// Shared types and helpers for the buffer-allocation arbiter.
// Holds the FSM state encoding, the operation kind and the pointer-wrap helper.
package buf_alloc_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic {
        OP_ALLOC = 1'b0,
        OP_FREE  = 1'b1
    } op_t;

    function automatic int wrap_inc(input int value, input int modulus);
        return (value + 1) % modulus;
    endfunction

endpackage

// File: rtl/buf_alloc_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping around.
// Produces a one-hot grant, the granted index and a valid flag.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        int cand;
        // NOTE: every output gets a default first so no path through the block leaves one unassigned (no latch).
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = 0;
        for (int off = 0; off < N; off++) begin
            cand = (int'(ptr) + off) % N;
            if (!valid && req[cand]) begin
                valid       = 1'b1;
                idx         = IDX_W'(cand);
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/buf_alloc_arbiter.sv
// Serialises per-client alloc/free requests into single Wishbone cycles to buf_manager
// and returns the result to the owning client as a registered one-cycle ack.
module buf_alloc_arbiter
    import buf_alloc_arbiter_pkg::*;
#(
    parameter int                 NCLIENTS    = 4,
    parameter int                 ADDR_WIDTH  = 16,
    parameter int                 DATA_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] BUF_MGR_ADR = 16'h0000,
    parameter int                 TIMEOUT     = 15
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NCLIENTS-1:0]            cl_alloc_req,
    input  logic [NCLIENTS-1:0]            cl_free_req,
    input  logic [NCLIENTS*DATA_WIDTH-1:0] cl_free_id,
    output logic [NCLIENTS-1:0]            cl_alloc_ack,
    output logic [NCLIENTS-1:0]            cl_free_ack,
    output logic                           cl_fail,
    output logic [DATA_WIDTH-1:0]          cl_rsp_id,
    output logic [ADDR_WIDTH-1:0]          wbm_address,
    output logic [DATA_WIDTH-1:0]          wbm_writedata,
    input  logic [DATA_WIDTH-1:0]          wbm_readdata,
    output logic                           wbm_strobe,
    output logic                           wbm_cycle,
    output logic                           wbm_write,
    input  logic                           wbm_ack
);

    localparam int IDX_W = (NCLIENTS > 1) ? $clog2(NCLIENTS) : 1;
    localparam int TW    = $clog2(TIMEOUT + 1);
    localparam logic [DATA_WIDTH-1:0] EMPTY_ID = '1;

    state_t                state, state_next;
    op_t                   cur_op;
    logic [IDX_W-1:0]      cur_idx, rr_ptr, arb_idx;
    logic [TW-1:0]         timer;
    logic [NCLIENTS-1:0]   alloc_pend, free_pend, alloc_clr, free_clr, arb_grant;
    logic                  arb_valid, bus_end, free_sel;
    logic [DATA_WIDTH-1:0] free_id_q [NCLIENTS];

    rr_arbiter #(.N(NCLIENTS), .IDX_W(IDX_W)) u_rr (
        .req   (alloc_pend | free_pend),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    // A returned ID is served before an alloc of the same client so the pool refills first.
    assign free_sel    = |(arb_grant & free_pend);
    assign wbm_address = BUF_MGR_ADR;
    assign wbm_cycle   = wbm_strobe;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // The timer holds the number of BUS cycles already completed; ack wins over abort.
    always_comb begin
        state_next = state;
        bus_end    = 1'b0;
        alloc_clr  = '0;
        free_clr   = '0;
        case (state)
            S_IDLE: if (arb_valid) state_next = S_BUS;
            S_BUS: begin
                if (wbm_ack || timer == TW'(TIMEOUT - 1)) begin
                    bus_end    = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
                if (cur_op == OP_FREE) free_clr[cur_idx]  = 1'b1;
                else                   alloc_clr[cur_idx] = 1'b1;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: ID storage has no reset; an entry is only read while its free flag is set.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCLIENTS; i++) begin
            if (cl_free_req[i] && (!free_pend[i] || free_clr[i]))
                free_id_q[i] <= cl_free_id[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            alloc_pend    <= '0;
            free_pend     <= '0;
            rr_ptr        <= '0;
            cur_idx       <= '0;
            cur_op        <= OP_ALLOC;
            timer         <= '0;
            wbm_strobe    <= 1'b0;
            wbm_write     <= 1'b0;
            wbm_writedata <= '0;
            cl_alloc_ack  <= '0;
            cl_free_ack   <= '0;
            cl_fail       <= 1'b0;
            cl_rsp_id     <= '0;
        end else begin
            // NOTE: non-blocking updates keep every flop reading pre-edge values, whatever the statement order.
            alloc_pend   <= (alloc_pend & ~alloc_clr) | cl_alloc_req;
            free_pend    <= (free_pend & ~free_clr) | cl_free_req;
            cl_alloc_ack <= '0;
            cl_free_ack  <= '0;
            cl_fail      <= 1'b0;
            cl_rsp_id    <= '0;
            case (state)
                S_IDLE: begin
                    if (arb_valid) begin
                        cur_idx       <= arb_idx;
                        cur_op        <= free_sel ? OP_FREE : OP_ALLOC;
                        rr_ptr        <= IDX_W'(wrap_inc(int'(arb_idx), NCLIENTS));
                        wbm_strobe    <= 1'b1;
                        wbm_write     <= free_sel;
                        wbm_writedata <= free_sel ? free_id_q[arb_idx] : '0;
                        timer         <= '0;
                    end
                end
                S_BUS: begin
                    if (bus_end) begin
                        wbm_strobe    <= 1'b0;
                        wbm_write     <= 1'b0;
                        wbm_writedata <= '0;
                        if (cur_op == OP_FREE) begin
                            cl_free_ack[cur_idx] <= 1'b1;
                            cl_fail              <= !wbm_ack;
                        end else begin
                            cl_alloc_ack[cur_idx] <= 1'b1;
                            if (!wbm_ack || wbm_readdata == EMPTY_ID) cl_fail   <= 1'b1;
                            else                                      cl_rsp_id <= wbm_readdata;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_buf_alloc_arbiter.sv
// Directed bench for buf_alloc_arbiter: a single-transaction vector table plus
// hand-written sequences for round-robin order, same-client free/alloc, re-request, timeout and reset.
module tb_buf_alloc_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 16;
    localparam int TO = 15;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      cl_alloc_req = '0;
    logic [N-1:0]      cl_free_req = '0;
    logic [N*DW-1:0]   cl_free_id = '0;
    logic [N-1:0]      cl_alloc_ack, cl_free_ack;
    logic              cl_fail;
    logic [DW-1:0]     cl_rsp_id;
    logic [AW-1:0]     wbm_address;
    logic [DW-1:0]     wbm_writedata;
    logic [DW-1:0]     slave_rdata = '0;
    logic              wbm_strobe, wbm_cycle, wbm_write;
    logic              wbm_ack = 1'b0;
    bit                slave_en = 1'b1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct { int cyc; int client; bit is_free; bit fail; logic [DW-1:0] id; } ev_t;
    typedef struct { bit we; logic [DW-1:0] wdata; logic [AW-1:0] adr; int stb_cycles; } bus_t;
    typedef struct { int client; bit is_free; logic [DW-1:0] fid; logic [DW-1:0] rdata;
                     bit exp_fail; logic [DW-1:0] exp_id; } vec_t;

    ev_t  evq[$];
    bus_t busq[$];
    vec_t vecs[5];

    buf_alloc_arbiter #(
        .NCLIENTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BUF_MGR_ADR(16'h0000), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .cl_alloc_req(cl_alloc_req), .cl_free_req(cl_free_req), .cl_free_id(cl_free_id),
        .cl_alloc_ack(cl_alloc_ack), .cl_free_ack(cl_free_ack),
        .cl_fail(cl_fail), .cl_rsp_id(cl_rsp_id),
        .wbm_address(wbm_address), .wbm_writedata(wbm_writedata), .wbm_readdata(slave_rdata),
        .wbm_strobe(wbm_strobe), .wbm_cycle(wbm_cycle), .wbm_write(wbm_write), .wbm_ack(wbm_ack)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Slave model and monitor: ack in the second STB cycle, log bus cycles and client acks.
    initial begin
        int   run;
        bus_t cur;
        run = 0;
        cur = '{0, '0, '0, 0};
        forever begin
            @(negedge clk);
            if (wbm_strobe) begin
                if (run == 0) begin
                    cur.we    = wbm_write;
                    cur.wdata = wbm_writedata;
                    cur.adr   = wbm_address;
                end
                run = run + 1;
            end else if (run > 0) begin
                cur.stb_cycles = run;
                busq.push_back(cur);
                run = 0;
            end
            wbm_ack = slave_en && wbm_strobe && (run == 2);
            for (int i = 0; i < N; i++) begin
                if (cl_alloc_ack[i]) evq.push_back('{cyc, i, 1'b0, cl_fail, cl_rsp_id});
                if (cl_free_ack[i])  evq.push_back('{cyc, i, 1'b1, cl_fail, cl_rsp_id});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (time %0t, limit 200000)", $time);
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [N-1:0] a, input logic [N-1:0] f, input int fc,
                         input logic [DW-1:0] fid, output int c0);
        @(negedge clk);
        cl_alloc_req = a;
        cl_free_req  = f;
        cl_free_id[fc*DW +: DW] = fid;
        c0 = cyc;
        @(negedge clk);
        cl_alloc_req = '0;
        cl_free_req  = '0;
    endtask

    task automatic flush();
        evq.delete();
        busq.delete();
    endtask

    initial begin
        int c0;
        logic [N-1:0] a, f;

        vecs[0] = '{0, 1'b0, 32'h0,        32'h0000_0003, 1'b0, 32'h0000_0003};
        vecs[1] = '{1, 1'b0, 32'h0,        32'hFFFF_FFFF, 1'b1, 32'h0};
        vecs[2] = '{3, 1'b1, 32'h0000_0005, 32'h0000_0077, 1'b0, 32'h0};
        vecs[3] = '{2, 1'b0, 32'h0,        32'hABCD_1234, 1'b0, 32'hABCD_1234};
        vecs[4] = '{1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_alloc_ack", 64'(cl_alloc_ack), 0);
        check("rst_free_ack", 64'(cl_free_ack), 0);
        check("rst_fail", 64'(cl_fail), 0);
        check("rst_rsp_id", 64'(cl_rsp_id), 0);
        check("rst_stb", 64'(wbm_strobe), 0);
        check("rst_cyc", 64'(wbm_cycle), 0);
        check("rst_we", 64'(wbm_write), 0);
        check("rst_wdata", 64'(wbm_writedata), 0);
        check("rst_adr", 64'(wbm_address), 0);
        reset = 1'b0;
        flush();

        // Four simultaneous allocs from rr_ptr=0: served 0,1,2,3 four cycles apart
        slave_rdata = 32'h10;
        drive(4'b1111, 4'b0000, 0, '0, c0);
        repeat (22) @(negedge clk);
        check("rr_ack_count", 64'(evq.size()), 4);
        check("rr_bus_count", 64'(busq.size()), 4);
        for (int k = 0; k < 4 && k < evq.size(); k++) begin
            check($sformatf("rr_client_%0d", k), 64'(evq[k].client), 64'(k));
            check($sformatf("rr_cycle_%0d", k), 64'(evq[k].cyc - c0), 64'(4 + 4*k));
            check($sformatf("rr_id_%0d", k), 64'(evq[k].id), 64'h10);
        end
        for (int k = 0; k < busq.size(); k++)
            check($sformatf("rr_stb_len_%0d", k), 64'(busq[k].stb_cycles), 2);

        // Single-transaction vector table
        for (int v = 0; v < 5; v++) begin
            flush();
            slave_rdata = vecs[v].rdata;
            a = vecs[v].is_free ? 4'b0000 : (4'b0001 << vecs[v].client);
            f = vecs[v].is_free ? (4'b0001 << vecs[v].client) : 4'b0000;
            drive(a, f, vecs[v].client, vecs[v].fid, c0);
            repeat (10) @(negedge clk);
            check($sformatf("v%0d_ack_count", v), 64'(evq.size()), 1);
            check($sformatf("v%0d_bus_count", v), 64'(busq.size()), 1);
            if (evq.size() == 1) begin
                check($sformatf("v%0d_client", v), 64'(evq[0].client), 64'(vecs[v].client));
                check($sformatf("v%0d_kind", v), 64'(evq[0].is_free), 64'(vecs[v].is_free));
                check($sformatf("v%0d_latency", v), 64'(evq[0].cyc - c0), 4);
                check($sformatf("v%0d_fail", v), 64'(evq[0].fail), 64'(vecs[v].exp_fail));
                check($sformatf("v%0d_rsp_id", v), 64'(evq[0].id), 64'(vecs[v].exp_id));
            end
            if (busq.size() == 1) begin
                check($sformatf("v%0d_we", v), 64'(busq[0].we), 64'(vecs[v].is_free));
                check($sformatf("v%0d_adr", v), 64'(busq[0].adr), 0);
                if (vecs[v].is_free)
                    check($sformatf("v%0d_wdata", v), 64'(busq[0].wdata), 64'(vecs[v].fid));
            end
        end

        // Client 2 free(5) and alloc in the same cycle: write first, then read
        flush();
        slave_rdata = 32'h9;
        drive(4'b0100, 4'b0100, 2, 32'h5, c0);
        repeat (14) @(negedge clk);
        check("fa_ack_count", 64'(evq.size()), 2);
        check("fa_bus_count", 64'(busq.size()), 2);
        if (evq.size() == 2) begin
            check("fa_first_is_free", 64'(evq[0].is_free), 1);
            check("fa_first_cycle", 64'(evq[0].cyc - c0), 4);
            check("fa_second_is_alloc", 64'(evq[1].is_free), 0);
            check("fa_second_cycle", 64'(evq[1].cyc - c0), 8);
            check("fa_second_client", 64'(evq[1].client), 2);
            check("fa_second_id", 64'(evq[1].id), 9);
        end
        if (busq.size() == 2) begin
            check("fa_bus0_we", 64'(busq[0].we), 1);
            check("fa_bus0_wdata", 64'(busq[0].wdata), 5);
            check("fa_bus1_we", 64'(busq[1].we), 0);
        end

        // Repeated pulse while pending is dropped; pulse during DONE re-arms the flag
        flush();
        slave_rdata = 32'h42;
        drive(4'b0001, 4'b0000, 0, '0, c0);
        cl_alloc_req = 4'b0001;
        @(negedge clk);
        cl_alloc_req = 4'b0000;
        while (cyc < c0 + 4) @(negedge clk);
        cl_alloc_req = 4'b0001;
        @(negedge clk);
        cl_alloc_req = 4'b0000;
        repeat (14) @(negedge clk);
        check("re_ack_count", 64'(evq.size()), 2);
        if (evq.size() == 2) begin
            check("re_first_cycle", 64'(evq[0].cyc - c0), 4);
            check("re_second_cycle", 64'(evq[1].cyc - c0), 8);
        end

        // Slave never acks: STB held TIMEOUT cycles, then failed ack, then normal service
        flush();
        slave_en = 1'b0;
        drive(4'b0010, 4'b0000, 0, '0, c0);
        repeat (30) @(negedge clk);
        check("to_ack_count", 64'(evq.size()), 1);
        check("to_bus_count", 64'(busq.size()), 1);
        if (evq.size() == 1) begin
            check("to_cycle", 64'(evq[0].cyc - c0), 64'(TO + 2));
            check("to_fail", 64'(evq[0].fail), 1);
            check("to_rsp_id", 64'(evq[0].id), 0);
        end
        if (busq.size() == 1)
            check("to_stb_len", 64'(busq[0].stb_cycles), 64'(TO));
        flush();
        slave_en = 1'b1;
        slave_rdata = 32'h21;
        drive(4'b1000, 4'b0000, 0, '0, c0);
        repeat (10) @(negedge clk);
        check("post_to_ack_count", 64'(evq.size()), 1);
        if (evq.size() == 1) begin
            check("post_to_latency", 64'(evq[0].cyc - c0), 4);
            check("post_to_id", 64'(evq[0].id), 64'h21);
        end

        // Reset during BUS: STB/CYC drop, pending requests discarded, no acks
        flush();
        drive(4'b1001, 4'b0000, 0, '0, c0);
        @(negedge clk);
        check("mr_stb_before", 64'(wbm_strobe), 1);
        reset = 1'b1;
        @(negedge clk);
        check("mr_stb_after", 64'(wbm_strobe), 0);
        check("mr_cyc_after", 64'(wbm_cycle), 0);
        reset = 1'b0;
        flush();
        repeat (25) @(negedge clk);
        check("mr_no_acks", 64'(evq.size()), 0);
        check("mr_no_bus", 64'(busq.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
